// File: rtl/sev_seg_scan_capture.sv
// rtl/sev_seg_scan_capture.sv - reassembles a 16-bit word from a 4-digit seven-segment scan bus
// Synchronizes, debounces and order-checks the nibble/one-hot-enable pair.
module sev_seg_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dig_in,
  input  logic [3:0]  en_in,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        locked
);

  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  logic [7:0]  sync1, sync2;
  logic [7:0]  stable_cnt;
  logic        fired;
  logic [3:0]  s_en, s_dig;
  logic        same, strobe, blank, multi;
  logic [1:0]  k;
  logic [15:0] merged;

  state_t      state;
  logic [15:0] shadow;
  logic [1:0]  exp_k, last_k;
  logic [19:0] tcnt;

  assign s_en  = sync2[7:4];
  assign s_dig = sync2[3:0];
  assign same  = (sync1 == sync2);
  // Requiring sync1 to still match keeps runs shorter than SETTLE+2 from ever strobing.
  assign strobe = same && !fired && (stable_cnt == SETTLE_C);
  assign blank  = (s_en == 4'b0000);
  assign multi  = ((s_en & (s_en - 4'd1)) != 4'b0000);

  always_comb begin
    k = 2'd0;
    case (s_en)
      4'b0010: k = 2'd1;
      4'b0100: k = 2'd2;
      4'b1000: k = 2'd3;
      default: k = 2'd0;
    endcase
  end

  always_comb begin
    merged = shadow;
    merged[4*k +: 4] = s_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 8'h00;
      sync2      <= 8'h00;
      stable_cnt <= 8'd0;
      fired      <= 1'b0;
    end else begin
      sync1 <= {en_in, dig_in};
      sync2 <= sync1;
      if (!same) begin
        stable_cnt <= 8'd0;
        fired      <= 1'b0;
      end else begin
        if (stable_cnt != SETTLE_C)
          stable_cnt <= stable_cnt + 8'd1;
        if (strobe)
          fired <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      shadow     <= 16'h0000;
      exp_k      <= 2'd0;
      last_k     <= 2'd0;
      tcnt       <= 20'd0;
      word_out   <= 16'h0000;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        HUNT: begin
          tcnt <= 20'd0;
          if (strobe && !blank) begin
            if (multi) begin
              frame_err <= 1'b1;
              shadow    <= 16'h0000;
            end else if (k == 2'd0) begin
              shadow <= merged;
              exp_k  <= 2'd1;
              last_k <= 2'd0;
              state  <= LOCK;
              locked <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (strobe && !blank) begin
            tcnt <= 20'd0;
            if (multi) begin
              frame_err <= 1'b1;
              shadow    <= 16'h0000;
              state     <= HUNT;
              locked    <= 1'b0;
            end else if (k == exp_k) begin
              shadow <= merged;
              last_k <= k;
              if (k == 2'd3) begin
                word_out   <= merged;
                word_valid <= 1'b1;
                exp_k      <= 2'd0;
              end else begin
                exp_k <= exp_k + 2'd1;
              end
            end else if (k == last_k) begin
              // Same slot with a new value: a repeated slot 3 only feeds the next frame.
              shadow <= merged;
            end else begin
              frame_err <= 1'b1;
              if (k == 2'd0) begin
                shadow <= merged;
                exp_k  <= 2'd1;
                last_k <= 2'd0;
              end else begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end else if (tcnt == TO_LAST) begin
            tcnt      <= 20'd0;
            frame_err <= 1'b1;
            state     <= HUNT;
            locked    <= 1'b0;
          end else begin
            tcnt <= tcnt + 20'd1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_capture.sv
// tb/tb_sev_seg_scan_capture.sv - directed bench for sev_seg_scan_capture
// SETTLE=4, TIMEOUT=100; inputs change on the falling edge.
module tb_sev_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dig_in, en_in;
  logic [15:0] word_out;
  logic        word_valid, frame_err, locked;

  int n_chk = 0;
  int n_bad = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int wv0, fe0;

  sev_seg_scan_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .dig_in     (dig_in),
    .en_in      (en_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (word_valid) wv_cnt++;
    if (frame_err) fe_cnt++;
    if (word_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] dig, input int n);
    en_in  = en;
    dig_in = dig;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    drive(4'b0001, w[3:0], n);
    drive(4'b0010, w[7:4], n);
    drive(4'b0100, w[11:8], n);
    drive(4'b1000, w[15:12], n);
  endtask

  task automatic snap();
    wv0 = wv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    rst = 1'b1;
    en_in = 4'b0000;
    dig_in = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_wv", 32'(word_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_lock", 32'(locked), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // nominal scan of AF06, checking strobe latency on the first digit
    snap();
    en_in = 4'b0001;
    dig_in = 4'h6;
    repeat (6) @(negedge clk);
    check("lat_pre", 32'(locked), 32'h0);
    @(negedge clk);
    check("lat_post", 32'(locked), 32'h1);
    repeat (9) @(negedge clk);
    drive(4'b0010, 4'h0, 16);
    drive(4'b0100, 4'hF, 16);
    drive(4'b1000, 4'hA, 16);
    frame(16'hAF06, 16);
    frame(16'hAF06, 16);
    check("nom_wv", 32'(wv_cnt - wv0), 32'd3);
    check("nom_word", 32'(word_out), 32'hAF06);
    check("nom_fe", 32'(fe_cnt - fe0), 32'd0);
    check("nom_lock", 32'(locked), 32'h1);

    // 3-cycle glitch is filtered
    snap();
    drive(4'b0001, 4'h6, 16);
    drive(4'b0010, 4'h0, 16);
    drive(4'b0100, 4'hF, 8);
    drive(4'b0100, 4'h3, 3);
    drive(4'b0100, 4'hF, 8);
    drive(4'b1000, 4'hA, 16);
    check("glitch_wv", 32'(wv_cnt - wv0), 32'd1);
    check("glitch_word", 32'(word_out), 32'hAF06);

    // 10-cycle change overwrites nibble 2
    snap();
    drive(4'b0001, 4'h6, 16);
    drive(4'b0010, 4'h0, 16);
    drive(4'b0100, 4'hF, 8);
    drive(4'b0100, 4'h3, 10);
    drive(4'b1000, 4'hA, 16);
    check("ovw_wv", 32'(wv_cnt - wv0), 32'd1);
    check("ovw_word", 32'(word_out), 32'hA306);
    check("ovw_fe", 32'(fe_cnt - fe0), 32'd0);

    // order error 0001, 0010, 1000
    snap();
    drive(4'b0001, 4'h1, 16);
    drive(4'b0010, 4'h2, 16);
    drive(4'b1000, 4'h3, 16);
    check("ord_fe", 32'(fe_cnt - fe0), 32'd1);
    check("ord_wv", 32'(wv_cnt - wv0), 32'd0);
    check("ord_lock", 32'(locked), 32'h0);
    drive(4'b0001, 4'h4, 16);
    check("ord_relock", 32'(locked), 32'h1);

    // multi-hot enable
    snap();
    drive(4'b0011, 4'h0, 16);
    check("multi_fe", 32'(fe_cnt - fe0), 32'd1);
    check("multi_lock", 32'(locked), 32'h0);

    // digit 0 while expecting digit 2 resyncs in LOCK
    snap();
    drive(4'b0001, 4'hE, 16);
    drive(4'b0010, 4'h7, 16);
    drive(4'b0001, 4'hE, 16);
    check("resync_fe", 32'(fe_cnt - fe0), 32'd1);
    check("resync_lock", 32'(locked), 32'h1);
    drive(4'b0010, 4'h7, 16);
    drive(4'b0100, 4'hC, 16);
    drive(4'b1000, 4'h5, 16);
    check("resync_wv", 32'(wv_cnt - wv0), 32'd1);
    check("resync_word", 32'(word_out), 32'h5C7E);
    check("resync_fe2", 32'(fe_cnt - fe0), 32'd1);

    // timeout: digit 1 accepted at edge 6 of its run, drop lock 100 edges later
    drive(4'b0001, 4'h1, 16);
    snap();
    drive(4'b0010, 4'h2, 8);
    drive(4'b0000, 4'h0, 98);
    check("to_pre_lock", 32'(locked), 32'h1);
    check("to_pre_fe", 32'(fe_cnt - fe0), 32'd0);
    @(negedge clk);
    check("to_fe", 32'(frame_err), 32'h1);
    check("to_lock", 32'(locked), 32'h0);

    // reset mid-frame
    frame(16'hBEEF, 16);
    drive(4'b0001, 4'h4, 16);
    drive(4'b0010, 4'h3, 16);
    drive(4'b0100, 4'h2, 16);
    rst = 1'b1;
    #1;
    check("mrst_word", 32'(word_out), 32'h0);
    check("mrst_lock", 32'(locked), 32'h0);
    check("mrst_wv", 32'(word_valid), 32'h0);
    check("mrst_fe", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    snap();
    drive(4'b1000, 4'h1, 16);
    frame(16'h1234, 16);
    check("post_wv", 32'(wv_cnt - wv0), 32'd1);
    check("post_word", 32'(word_out), 32'h1234);
    check("both_high", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_capture.md
# sev_seg_scan_capture

Receiving end of the 4-digit seven-segment scan bus. Samples the time-multiplexed nibble/one-hot-enable pair produced by the display scan controller, which cycles digits 0..3 with `en` = 0001, 0010, 0100, 1000. Reassembles the original 16-bit word and checks scan ordering. Sits on the board-loopback or self-test path, and in benches as a monitor for any scan-driven display interface.

## Interface
- `SETTLE`, default 4: consecutive cycles the synchronized `{en_in, dig_in}` pair must be constant before it is sampled (range 1..255).
- `TIMEOUT`, default 20000: cycles allowed in LOCK without an accepted digit before lock is dropped. Must exceed the source dwell time (8192 cycles in the production scan). Range 1..2^20-1.
- `clk` input 1: clock; all state on its rising edge.
- `rst` input 1: reset rst, asynchronous, active-high.
- `dig_in` input 4: scanned nibble (source `binOUT`).
- `en_in` input 4: scanned one-hot digit enable (source `en_bus`). Bit k selects `word[4k+3:4k]`.
- `word_out` output 16: last fully assembled word. Holds between frames.
- `word_valid` output 1: one-cycle pulse when `word_out` is updated.
- `frame_err` output 1: one-cycle pulse on a protocol violation.
- `locked` output 1: high while in LOCK state.

## Operation
- **Input stage**
  - Two-flop synchronizer on `{en_in, dig_in}`, producing `s_en` and `s_dig`.
  - `stable_cnt` resets to 0 whenever the synchronized pair differs from its previous-cycle value.
  - Otherwise `stable_cnt` increments, saturating at `SETTLE`.
  - A strobe fires exactly once per stable run, on the cycle `stable_cnt` reaches `SETTLE`.
- **Strobe classification**
  - `s_en` = 0000: blanking. Ignored, with no error and no state change.
  - `s_en` with popcount > 1: bad. Pulse `frame_err`, go to HUNT, discard the shadow word.
  - Otherwise the strobe is one-hot with index k, handled as below.
- **States**
  - HUNT:
    - A strobe with k=0 loads `shadow[3:0]` and sets `expect`=1 and `last`=0, then enters LOCK.
    - Other one-hot strobes are ignored silently.
  - LOCK, strobe with k == `expect`:
    - Load `shadow[4k+3:4k]` and set `last`=k.
    - If k<3, increment `expect`.
    - If k==3, `word_out` <= shadow with the new nibble merged, pulse `word_valid`, and set `expect`=0.
  - LOCK, strobe with k == `last`:
    - The digit value changed within the same slot. Overwrite that nibble in shadow.
    - No error and no pulse.
    - If `last`==3, do not re-emit: the word was already delivered, and the new nibble applies to the next frame's slot 3.
  - LOCK, any other one-hot k:
    - Pulse `frame_err`.
    - If k==0, resync immediately: load `shadow[3:0]`, set `expect`=1, `last`=0, and stay in LOCK.
    - Otherwise go to HUNT.
- **Timeout**
  - A 20-bit counter clears on every accepted or overwrite strobe and on entry to LOCK.
  - It increments each cycle in LOCK.
  - On reaching `TIMEOUT`: go to HUNT and pulse `frame_err`.
  - The counter is idle (held at 0) in HUNT.
- **Simultaneous events**: a strobe and a timeout in the same cycle resolve in favour of the strobe; the counter clears.
- `locked` = (state == LOCK), registered.

## Timing
- **Reset values**:
  - outputs: `word_out`=0000h, `word_valid`=0, `frame_err`=0, `locked`=0;
  - internal: state=HUNT, shadow=0, `expect`=0, `last`=0, `stable_cnt`=0, sync flops=0, timeout counter=0.
- **Latency**: inputs set up before edge E and held constant give the strobe at edge E+1+SETTLE. Registered outputs (`word_valid`, `word_out`, `frame_err`, `locked`) change at edge E+2+SETTLE.
- **Minimum dwell**: each digit must be held ≥ SETTLE+2 cycles to be captured. Shorter runs, including glitches, never strobe.
- **Back-to-back frames**: `word_valid` pulses are separated by at least 4×(SETTLE+2) cycles. No internal backpressure; the consumer must take `word_out` on the pulse or whenever it is stable.
- **Reset mid-frame**: all state clears asynchronously. After release, capture restarts from HUNT and the partial frame is lost.
- **Error pulses**: `frame_err` and `word_valid` are never high in the same cycle.

## Test plan
- **Nominal scan**: drive 16'hAF06, dwell 16 cycles per digit, 0001→1000 repeating, SETTLE=4. Require `word_valid` once per 64-cycle scan, `word_out`=16'hAF06, `locked`=1 from the first 0001 strobe, no `frame_err`.
- **Glitch rejection**: during the 0100 slot, flip `dig_in` to 4'h3 for 3 cycles, then return. Require no overwrite and `word_out` still 16'hAF06. A 10-cycle flip instead overwrites nibble 2, giving next `word_out`=16'hA306.
- **Order error**: sequence 0001, 0010, 1000. Require a `frame_err` pulse at the 1000 strobe, `locked`=0, and no `word_valid`. A following 0001 relocks.
- **Multi-hot and resync**: inject `en_in`=0011 → `frame_err`, HUNT. Separately, inject 0001 while `expect`=2 → `frame_err` with `locked` staying 1, then a full frame yields the correct word.
- **Timeout**: with TIMEOUT=100, hold `en_in`=0000 after digit 1. Require a `frame_err` pulse and `locked`=0 exactly 100 cycles after the last accepted strobe.
- **Reset mid-frame**: assert `rst` for 1 cycle after digit 2. Require all outputs at reset values immediately, and the next complete scan of 16'h1234 yields `word_out`=16'h1234 with exactly one `word_valid`.
